// File: rtl/ptl_pkg.sv
// Shared definitions for the PTL transmit framer: FSM state encoding,
// frame length arithmetic and the parity helper.
package ptl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        GUARD  = 3'd4
    } ptl_state_e;

    // Handshake-to-IDLE distance in clock cycles.
    function automatic int frame_cycles(input int width, input int slot_cycles,
                                        input int parity_en, input int guard_slots);
        return (1 + width + parity_en + guard_slots) * slot_cycles;
    endfunction

    // Even-parity bit: 1 when the word holds an odd number of ones.
    function automatic logic ptl_even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ptl_slot_timer.sv
// Slot timer: counts clock cycles within a bit slot and flags the edge
// that opens the next slot. Held at zero while the framer is idle.
module ptl_slot_timer #(
    parameter int SLOT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic slot_start
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // High in the last cycle of a slot, so the following edge starts a new slot.
    assign slot_start = run && (cnt_r == CNT_LAST);

    // Cycle counter, reloaded explicitly at the slot boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!run) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ptl_tx_framer.sv
// PTL transmit framer: serialises a word as SFQ pulses (q level toggles),
// one slot per start/data/parity bit, followed by pulse-free guard slots.
module ptl_tx_framer
    import ptl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SLOT_CYCLES = 3,
    parameter int PARITY_EN   = 1,
    parameter int GUARD_SLOTS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             q,
    output logic             busy,
    output logic             pulse
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "ptl_tx_framer: WIDTH must be in 1..32");
    end
    if (SLOT_CYCLES < 2) begin : g_bad_slot
        $fatal(1, "ptl_tx_framer: SLOT_CYCLES must be at least 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity
        $fatal(1, "ptl_tx_framer: PARITY_EN must be 0 or 1");
    end
    if (GUARD_SLOTS < 1) begin : g_bad_guard
        $fatal(1, "ptl_tx_framer: GUARD_SLOTS must be at least 1");
    end

    localparam int BIDX_W  = $clog2(WIDTH + 1);
    localparam int GUARD_W = $clog2(GUARD_SLOTS + 1);
    localparam logic [BIDX_W-1:0]  BIT_LAST   = BIDX_W'(WIDTH);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_SLOTS - 1);

    ptl_state_e         state_r;
    ptl_state_e         state_nxt_s;
    logic [WIDTH-1:0]   shift_r;
    logic [WIDTH-1:0]   shift_nxt_s;
    logic [BIDX_W-1:0]  bit_idx_r;
    logic [BIDX_W-1:0]  bit_idx_nxt_s;
    logic [GUARD_W-1:0] guard_r;
    logic [GUARD_W-1:0] guard_nxt_s;
    logic               par_r;
    logic               par_nxt_s;
    logic               q_r;
    logic               pulse_r;
    logic               toggle_s;
    logic               slot_start_s;
    logic               busy_s;

    assign busy_s   = (state_r != IDLE);
    assign in_ready = (state_r == IDLE) && !rst;
    assign busy     = busy_s;
    assign q        = q_r;
    assign pulse    = pulse_r;

    ptl_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (busy_s),
        .slot_start (slot_start_s)
    );

    // Next-state logic; toggle_s marks the edges that emit a pulse.
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_idx_nxt_s = bit_idx_r;
        guard_nxt_s   = guard_r;
        par_nxt_s     = par_r;
        toggle_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    toggle_s      = 1'b1;
                    shift_nxt_s   = in_data;
                    par_nxt_s     = ptl_even_parity(32'(in_data));
                    bit_idx_nxt_s = '0;
                    state_nxt_s   = START;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            START: begin
                if (slot_start_s) begin
                    toggle_s      = shift_r[0];
                    shift_nxt_s   = shift_r >> 1'b1;
                    bit_idx_nxt_s = BIDX_W'(1);
                    state_nxt_s   = DATA;
                end else begin
                    state_nxt_s   = START;
                end
            end
            DATA: begin
                // bit_idx_r counts bits already sent; at WIDTH the data phase is over.
                if (slot_start_s && (bit_idx_r == BIT_LAST)) begin
                    if (PARITY_EN != 0) begin
                        toggle_s    = par_r;
                        state_nxt_s = PARITY;
                    end else begin
                        guard_nxt_s = '0;
                        state_nxt_s = GUARD;
                    end
                end else if (slot_start_s) begin
                    toggle_s      = shift_r[0];
                    shift_nxt_s   = shift_r >> 1'b1;
                    bit_idx_nxt_s = bit_idx_r + BIDX_W'(1);
                end else begin
                    state_nxt_s   = DATA;
                end
            end
            PARITY: begin
                if (slot_start_s) begin
                    guard_nxt_s = '0;
                    state_nxt_s = GUARD;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            GUARD: begin
                if (slot_start_s && (guard_r == GUARD_LAST)) begin
                    state_nxt_s = IDLE;
                end else if (slot_start_s) begin
                    guard_nxt_s = guard_r + GUARD_W'(1);
                end else begin
                    state_nxt_s = GUARD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts a frame and forces q low silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            bit_idx_r <= '0;
            guard_r   <= '0;
            par_r     <= 1'b0;
            q_r       <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            guard_r   <= guard_nxt_s;
            par_r     <= par_nxt_s;
            q_r       <= q_r ^ toggle_s;
            pulse_r   <= toggle_s;
        end
    end

endmodule
